// File: rtl/router_req_scheduler.sv
// Round-robin scheduler sharing one router start port among NUM_LANES DFX requesters.
// Grants a lane, strobes router_start_req, then waits for router_ack or a timeout.
module router_req_scheduler #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          lane_req,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_src_addr,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_dst_addr,
  input  logic [NUM_LANES*2-1:0]        lane_dst_dfx,
  output logic [NUM_LANES-1:0]          lane_done,
  output logic [NUM_LANES-1:0]          lane_err,
  output logic                          router_start_req,
  output logic [ADDR_W-1:0]             router_scr_addr,
  output logic [ADDR_W-1:0]             router_dst_addr,
  output logic [1:0]                    router_src_dfx,
  output logic [1:0]                    router_dst_dfx,
  input  logic                          router_ack,
  output logic                          busy
);

  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IssW  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [IssW-1:0] IssLast = IssW'(START_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_e;

  state_e               state_q, state_d;
  logic [LaneW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LaneW-1:0]     grant_q, grant_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IssW-1:0]      iss_q, iss_d;
  logic                 start_q, start_d;
  logic [ADDR_W-1:0]    scr_q, scr_d;
  logic [ADDR_W-1:0]    dst_q, dst_d;
  logic [1:0]           src_dfx_q, src_dfx_d;
  logic [1:0]           dst_dfx_q, dst_dfx_d;
  logic [NUM_LANES-1:0] done_q, done_d;
  logic [NUM_LANES-1:0] err_q, err_d;
  logic                 busy_q, busy_d;

  logic [LaneW-1:0]     cand;
  logic [LaneW-1:0]     win;
  logic                 win_valid;
  logic [1:0]           win_dfx;
  logic                 win_illegal;

  // Scan from rr_ptr+NUM_LANES down to rr_ptr+1 so the nearest requester after rr_ptr wins last.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      cand = LaneW'((int'(rr_ptr_q) + i) % NUM_LANES);
      if (lane_req[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
    win_dfx     = lane_dst_dfx[int'(win)*2 +: 2];
    win_illegal = (win_dfx == 2'(win));
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    iss_d     = iss_q;
    start_d   = start_q;
    scr_d     = scr_q;
    dst_d     = dst_q;
    src_dfx_d = src_dfx_q;
    dst_dfx_d = dst_dfx_q;
    done_d    = '0;
    err_d     = '0;

    case (state_q)
      StIdle: begin
        if (win_valid) begin
          if (win_illegal) begin
            err_d    = NUM_LANES'(1) << win;
            rr_ptr_d = win;
          end else begin
            grant_d   = win;
            scr_d     = lane_src_addr[int'(win)*ADDR_W +: ADDR_W];
            dst_d     = lane_dst_addr[int'(win)*ADDR_W +: ADDR_W];
            dst_dfx_d = win_dfx;
            src_dfx_d = 2'(win);
            start_d   = 1'b1;
            iss_d     = '0;
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        if (iss_q == IssLast) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = StWaitAck;
        end else begin
          iss_d = iss_q + 1'b1;
        end
      end
      StWaitAck: begin
        // Ack takes precedence over a timeout expiring on the same edge.
        if (router_ack) begin
          done_d   = NUM_LANES'(1) << grant_q;
          rr_ptr_d = grant_q;
          state_d  = StIdle;
        end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
          err_d    = NUM_LANES'(1) << grant_q;
          rr_ptr_d = grant_q;
          state_d  = StIdle;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= LaneW'(NUM_LANES - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      iss_q     <= '0;
      start_q   <= 1'b0;
      scr_q     <= '0;
      dst_q     <= '0;
      src_dfx_q <= '0;
      dst_dfx_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      iss_q     <= iss_d;
      start_q   <= start_d;
      scr_q     <= scr_d;
      dst_q     <= dst_d;
      src_dfx_q <= src_dfx_d;
      dst_dfx_q <= dst_dfx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign lane_done        = done_q;
  assign lane_err         = err_q;
  assign router_start_req = start_q;
  assign router_scr_addr  = scr_q;
  assign router_dst_addr  = dst_q;
  assign router_src_dfx   = src_dfx_q;
  assign router_dst_dfx   = dst_dfx_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_router_req_scheduler.sv
// Directed bench for router_req_scheduler: table of single-lane transfers plus
// hand-written sequences for round-robin order, ack filtering and mid-transfer reset.
module tb_router_req_scheduler;

  localparam int NL = 4;
  localparam int AW = 10;
  localparam int TOUT = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL-1:0]    lane_req;
  logic [NL*AW-1:0] lane_src_addr;
  logic [NL*AW-1:0] lane_dst_addr;
  logic [NL*2-1:0]  lane_dst_dfx;
  logic [NL-1:0]    lane_done;
  logic [NL-1:0]    lane_err;
  logic             router_start_req;
  logic [AW-1:0]    router_scr_addr;
  logic [AW-1:0]    router_dst_addr;
  logic [1:0]       router_src_dfx;
  logic [1:0]       router_dst_dfx;
  logic             router_ack;
  logic             busy;

  router_req_scheduler #(
    .NUM_LANES(4), .ADDR_W(10), .START_CYCLES(2), .TIMEOUT(256)
  ) dut (
    .clk(clk), .rst(rst),
    .lane_req(lane_req), .lane_src_addr(lane_src_addr), .lane_dst_addr(lane_dst_addr),
    .lane_dst_dfx(lane_dst_dfx), .lane_done(lane_done), .lane_err(lane_err),
    .router_start_req(router_start_req), .router_scr_addr(router_scr_addr),
    .router_dst_addr(router_dst_addr), .router_src_dfx(router_src_dfx),
    .router_dst_dfx(router_dst_dfx), .router_ack(router_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lane_req      = '0;
    lane_src_addr = '0;
    lane_dst_addr = '0;
    lane_dst_dfx  = '0;
    router_ack    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [33:0] all_outs();
    return {router_start_req, router_scr_addr, router_dst_addr, router_src_dfx,
            router_dst_dfx, busy, lane_done, lane_err};
  endfunction

  // ack_delay: wait cycles after start drops before the ack pulse; -1 = never ack.
  // exp_start_cycles = 0 marks an illegal request.
  typedef struct {
    int         lane;
    logic [9:0] src;
    logic [9:0] dst;
    logic [1:0] dfx;
    int         ack_delay;
    logic [3:0] exp_done;
    logic [3:0] exp_err;
    int         exp_start_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic early;
    string tag;
    tag = $sformatf("v%0d", idx);
    lane_req = 4'(1) << v.lane;
    lane_src_addr[v.lane*AW +: AW] = v.src;
    lane_dst_addr[v.lane*AW +: AW] = v.dst;
    lane_dst_dfx[v.lane*2 +: 2]    = v.dfx;
    step();
    if (v.exp_start_cycles == 0) begin
      check({tag, "_illegal_err"}, lane_err, v.exp_err);
      check({tag, "_illegal_no_start"}, router_start_req, 0);
      lane_req = '0;
      step();
      check({tag, "_illegal_after"}, {router_start_req, busy, lane_err, lane_done}, 0);
    end else begin
      check({tag, "_start"}, router_start_req, 1);
      check({tag, "_scr"}, router_scr_addr, v.src);
      check({tag, "_dst"}, router_dst_addr, v.dst);
      check({tag, "_src_dfx"}, router_src_dfx, v.lane);
      check({tag, "_dst_dfx"}, router_dst_dfx, v.dfx);
      check({tag, "_busy"}, busy, 1);
      lane_req = '0;  // dropping req after grant must not cancel the transfer
      n = 1;
      for (int k = 0; k < 20; k++) begin
        step();
        if (!router_start_req) break;
        n++;
      end
      check({tag, "_start_cycles"}, n, v.exp_start_cycles);
      if (v.ack_delay < 0) begin
        n = 0;
        while (lane_err == 0 && lane_done == 0 && n < TOUT + 100) begin
          step();
          n++;
        end
        check({tag, "_timeout_cycles"}, n, TOUT);
      end else begin
        early = 1'b0;
        for (int k = 0; k < v.ack_delay; k++) begin
          step();
          early |= |(lane_done | lane_err) | ~busy;
        end
        check({tag, "_no_early_end"}, early, 0);
        router_ack = 1'b1;
        step();
        router_ack = 1'b0;
      end
      check({tag, "_done"}, lane_done, v.exp_done);
      check({tag, "_err"}, lane_err, v.exp_err);
      check({tag, "_busy_end"}, busy, 0);
      step();
      check({tag, "_pulse_end"}, {lane_done, lane_err}, 0);
    end
    clear_inputs();
  endtask

  initial begin
    int n;
    int exp_lane;

    vecs[0] = '{lane: 1, src: 10'h001, dst: 10'h005, dfx: 2'd2, ack_delay: 20,
                exp_done: 4'b0010, exp_err: 4'b0000, exp_start_cycles: 2};
    vecs[1] = '{lane: 1, src: 10'h000, dst: 10'h007, dfx: 2'd3, ack_delay: -1,
                exp_done: 4'b0000, exp_err: 4'b0010, exp_start_cycles: 2};
    vecs[2] = '{lane: 2, src: 10'h3AB, dst: 10'h155, dfx: 2'd0, ack_delay: 0,
                exp_done: 4'b0100, exp_err: 4'b0000, exp_start_cycles: 2};
    vecs[3] = '{lane: 2, src: 10'h111, dst: 10'h222, dfx: 2'd2, ack_delay: 0,
                exp_done: 4'b0000, exp_err: 4'b0100, exp_start_cycles: 0};
    vecs[4] = '{lane: 0, src: 10'h0F0, dst: 10'h30F, dfx: 2'd1, ack_delay: 3,
                exp_done: 4'b0001, exp_err: 4'b0000, exp_start_cycles: 2};
    vecs[5] = '{lane: 3, src: 10'h2C3, dst: 10'h13C, dfx: 2'd0, ack_delay: 255,
                exp_done: 4'b1000, exp_err: 4'b0000, exp_start_cycles: 2};
    vecs[6] = '{lane: 0, src: 10'h055, dst: 10'h0AA, dfx: 2'd0, ack_delay: 0,
                exp_done: 4'b0000, exp_err: 4'b0001, exp_start_cycles: 0};

    do_reset();
    check("reset_outputs", all_outs(), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Acks outside WAIT_ACK are discarded.
    router_ack = 1'b1;
    step();
    router_ack = 1'b0;
    check("idle_ack_ignored", {lane_done, lane_err, busy, router_start_req}, 0);
    lane_req = 4'b1000;
    lane_src_addr[3*AW +: AW] = 10'h2AA;
    lane_dst_dfx[3*2 +: 2] = 2'd0;
    step();
    check("issue_ack_grant", {router_start_req, router_src_dfx}, {1'b1, 2'd3});
    router_ack = 1'b1;
    step();
    router_ack = 1'b0;
    check("issue_ack_ignored", {router_start_req, lane_done}, {1'b1, 4'b0000});
    lane_req = '0;
    step();
    check("issue_ack_drop", {router_start_req, busy}, {1'b0, 1'b1});
    step();
    step();
    step();
    check("issue_ack_still_waiting", {busy, lane_done, lane_err}, {1'b1, 8'h00});
    router_ack = 1'b1;
    step();
    router_ack = 1'b0;
    check("fresh_ack_done", lane_done, 4'b1000);
    clear_inputs();
    step();

    // Round-robin with all lanes requesting right after reset.
    do_reset();
    lane_dst_dfx = {2'd0, 2'd3, 2'd2, 2'd1};
    for (int i = 0; i < NL; i++) lane_src_addr[i*AW +: AW] = 10'(16 * i + 1);
    lane_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_lane = t % NL;
      n = 0;
      while (!router_start_req && n < 10) begin
        step();
        n++;
      end
      check($sformatf("rr%0d_grant", t), router_src_dfx, exp_lane);
      check($sformatf("rr%0d_scr", t), router_scr_addr, 16 * exp_lane + 1);
      n = 0;
      while (router_start_req && n < 10) begin
        step();
        n++;
      end
      for (int k = 0; k < 4; k++) step();
      router_ack = 1'b1;
      step();
      router_ack = 1'b0;
      check($sformatf("rr%0d_done", t), {lane_done, lane_err}, {4'(1) << exp_lane, 4'b0000});
      if (t == 4) lane_req = '0;
    end
    step();

    // Reset during WAIT_ACK aborts silently and restores lane 0 priority.
    lane_req = 4'b0010;
    step();
    check("rst_pre_grant", router_src_dfx, 1);
    lane_req = '0;
    step();
    step();
    step();
    check("rst_pre_wait", {busy, router_start_req}, {1'b1, 1'b0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_outputs", all_outs(), 0);
    router_ack = 1'b1;
    step();
    router_ack = 1'b0;
    check("rst_late_ack", {lane_done, lane_err, busy}, 0);
    lane_req = 4'b0011;
    step();
    check("rst_next_grant", {router_start_req, router_src_dfx}, {1'b1, 2'd0});
    lane_req = '0;
    step();
    step();
    router_ack = 1'b1;
    step();
    router_ack = 1'b0;
    check("rst_next_done", lane_done, 4'b0001);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
